// File: rtl/universal_shift_register.sv
// ---------------------------------------------------------------------------
// universal_shift_register
//   WIDTH-bit synchronous register with hold, shift right, shift left and
//   parallel load. The operation is picked by a 2-bit mode code and gated by
//   a clock enable. q is taken straight from the flops, so there is no
//   combinational path from any input to the output.
// ---------------------------------------------------------------------------
module universal_shift_register #(
   parameter int WIDTH = 8  // register width, must be at least 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic             serial_in_right,
   input  logic             serial_in_left,
   input  logic [WIDTH-1:0] parallel_in,
   output logic [WIDTH-1:0] q
);

   // Operation encoding, named so the case arms read as intent.
   typedef enum logic [1:0] {
      MODE_HOLD        = 2'b00,
      MODE_SHIFT_RIGHT = 2'b01,
      MODE_SHIFT_LEFT  = 2'b10,
      MODE_LOAD        = 2'b11
   } mode_e;

   mode_e            mode_sel;
   logic [WIDTH-1:0] q_next;

   assign mode_sel = mode_e'(mode);

   // Next-state selection: pick the new contents from mode, gated by enable.
   always_comb begin
      // NOTE: q_next gets a default before any branch so every path assigns
      // it; without this the combinational block would infer a latch.
      q_next = q;
      if (enable) begin
         case (mode_sel)
            MODE_HOLD:        q_next = q;
            // Right shift: new bit enters at the MSB, the old LSB drops out.
            MODE_SHIFT_RIGHT: q_next = {serial_in_right, q[WIDTH-1:1]};
            // Left shift: new bit enters at the LSB, the old MSB drops out.
            MODE_SHIFT_LEFT:  q_next = {q[WIDTH-2:0], serial_in_left};
            MODE_LOAD:        q_next = parallel_in;
            default:          q_next = q;
         endcase
      end
   end

   // State register: asynchronous clear, otherwise capture q_next each edge.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignment keeps every flop sampling the values
      // from before the edge, independent of statement order.
      if (rst) begin
         q <= '0;
      end else begin
         q <= q_next;
      end
   end

endmodule

// File: tb/tb_universal_shift_register.sv
// ---------------------------------------------------------------------------
// tb_universal_shift_register
//   Directed plus random stimulus for universal_shift_register (WIDTH=8).
//   The stimulus process drives inputs on the falling edge and pushes the
//   expected q into a scoreboard queue; the monitor pops one entry after
//   each rising edge and compares it with q.
// ---------------------------------------------------------------------------
module tb_universal_shift_register;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             enable;
   logic [1:0]       mode;
   logic             serial_in_right;
   logic             serial_in_left;
   logic [WIDTH-1:0] parallel_in;
   logic [WIDTH-1:0] q;

   int checks   = 0;
   int failures = 0;

   // Scoreboard: expected value and a tag for each pending clock edge.
   logic [WIDTH-1:0] exp_q[$];
   string            name_q[$];

   // Bench-side copy of the register contents, for the random phase.
   logic [WIDTH-1:0] model_q;

   universal_shift_register #(.WIDTH(WIDTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .mode            (mode),
      .serial_in_right (serial_in_right),
      .serial_in_left  (serial_in_left),
      .parallel_in     (parallel_in),
      .q               (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference behaviour of one rising edge with rst low.
   function automatic logic [WIDTH-1:0] model_next(
      input logic [WIDTH-1:0] cur, input logic en, input logic [1:0] md,
      input logic sr, input logic sl, input logic [WIDTH-1:0] pin);
      if (!en) return cur;
      case (md)
         2'b00:   return cur;
         2'b01:   return {sr, cur[WIDTH-1:1]};
         2'b10:   return {cur[WIDTH-2:0], sl};
         default: return pin;
      endcase
   endfunction

   // One stimulus cycle with a hand-computed expected result.
   task automatic step(input logic en, input logic [1:0] md, input logic sr,
                       input logic sl, input logic [WIDTH-1:0] pin,
                       input logic [WIDTH-1:0] expected, input string name);
      @(negedge clk);
      enable          = en;
      mode            = md;
      serial_in_right = sr;
      serial_in_left  = sl;
      parallel_in     = pin;
      exp_q.push_back(expected);
      name_q.push_back(name);
      model_q = expected;
   endtask

   // Monitor: one scoreboard entry per rising edge while entries are pending.
   initial begin
      logic [WIDTH-1:0] e;
      string            n;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, 32'(q), 32'(e));
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Stimulus.
   initial begin
      logic             r_en, r_sr, r_sl;
      logic [1:0]       r_md;
      logic [WIDTH-1:0] r_pin, r_exp;

      rst             = 1'b1;
      enable          = 1'b0;
      mode            = 2'b00;
      serial_in_right = 1'b0;
      serial_in_left  = 1'b0;
      parallel_in     = '0;
      model_q         = '0;

      // Reset held for two rising edges, then released on a falling edge.
      #1;
      check("reset_initial", 32'(q), 32'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_release", 32'(q), 32'h00);

      // Enable gating: load requested but enable low.
      step(1'b0, 2'b11, 1'b0, 1'b0, 8'hFF, 8'h00, "enable_low_load");

      // Load and hold.
      step(1'b1, 2'b11, 1'b0, 1'b0, 8'hFF, 8'hFF, "load_ff");
      step(1'b1, 2'b00, 1'b1, 1'b1, 8'h00, 8'hFF, "hold_ignores_inputs");

      // Shifts starting from FF.
      step(1'b1, 2'b01, 1'b0, 1'b1, 8'h00, 8'h7F, "shr_in0");
      step(1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 8'hBF, "shr_in1");
      step(1'b1, 2'b10, 1'b1, 1'b0, 8'h00, 8'h7E, "shl_in0");
      step(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 8'hFD, "shl_in1");

      // Asynchronous reset mid-cycle while q=FF.
      step(1'b1, 2'b11, 1'b0, 1'b0, 8'hFF, 8'hFF, "load_ff_before_rst");
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_reset_midcycle", 32'(q), 32'h00);
      @(negedge clk);
      rst     = 1'b0;
      model_q = '0;
      enable  = 1'b0;

      // Rapid mode changes from AA.
      step(1'b1, 2'b11, 1'b0, 1'b0, 8'hAA, 8'hAA, "load_aa");
      step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 8'hAA, "rapid_hold");
      step(1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 8'hD5, "rapid_shr");
      step(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 8'hAB, "rapid_shl");
      step(1'b1, 2'b11, 1'b0, 1'b0, 8'hFF, 8'hFF, "rapid_load");

      // Walking one towards the MSB.
      step(1'b1, 2'b11, 1'b0, 1'b0, 8'h01, 8'h01, "walk_load");
      for (int i = 1; i < WIDTH; i++) begin
         step(1'b1, 2'b10, 1'b1, 1'b0, 8'h00, WIDTH'(1) << i, $sformatf("walk_%0d", i));
      end

      // Random cycles checked against the bench model.
      for (int i = 0; i < 100; i++) begin
         r_en  = 1'($urandom_range(0, 1));
         r_md  = 2'($urandom_range(0, 3));
         r_sr  = 1'($urandom_range(0, 1));
         r_sl  = 1'($urandom_range(0, 1));
         r_pin = WIDTH'($urandom());
         r_exp = model_next(model_q, r_en, r_md, r_sr, r_sl, r_pin);
         step(r_en, r_md, r_sr, r_sl, r_pin, r_exp, $sformatf("random_%0d", i));
      end

      // Let the monitor drain, then confirm every expectation was consumed.
      @(negedge clk);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
